// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares the unified instruction/data memory of the multicycle MIPS core
// between the CPU memory port and the program loader/debug port. Each
// access runs as IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> RESP, with a
// one-cycle acknowledge in RESP and at least one IDLE cycle between
// accesses. The loader is protected from starvation by a streak counter
// that limits how many CPU grants may pass it by.
//
// Ports:
//   clk, rst              clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata CPU request, held until cpu_ack
//   cpu_rdata, cpu_ack    CPU read data (held between reads), done pulse
//   cpu_stall             cpu_req & ~cpu_ack, to the main decoder
//   ld_req/we/addr/wdata  loader request, held until ld_ack
//   ld_rdata, ld_ack      loader read data (held between reads), done pulse
//   mem_en/we/addr/wdata  memory controls, all zero outside ACCESS
//   mem_rdata             combinational memory read data
//   grant_ld              owner of the current/last access (1 = loader)

module mem_port_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned WAIT_CYCLES    = 2,
  parameter int unsigned MAX_CPU_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant_ld
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT   = 4'(WAIT_CYCLES);
  localparam logic [3:0] MAX_STREAK = 4'(MAX_CPU_STREAK);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        streak_q, streak_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              grant_ld_q, grant_ld_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;

  logic ld_wins;
  logic last_beat;

  // The loader wins when it is alone, or when the CPU has used up its
  // allowance of consecutive grants while the loader was waiting.
  assign ld_wins   = ld_req & (~cpu_req | (streak_q == MAX_STREAK));
  assign last_beat = (state_q == ACCESS) && (cnt_q == LAST_CNT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    grant_ld_d  = grant_ld_q;
    cpu_rdata_d = cpu_rdata_q;
    ld_rdata_d  = ld_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (cpu_req || ld_req) begin
          state_d    = ACCESS;
          cnt_d      = 4'd0;
          grant_ld_d = ld_wins;
          if (ld_wins) begin
            addr_d  = ld_addr;
            wdata_d = ld_wdata;
            we_d    = ld_we;
          end else begin
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
            we_d    = cpu_we;
          end
        end

        // Streak only counts CPU grants that made the loader wait.
        if (!ld_req || ld_wins) begin
          streak_d = 4'd0;
        end else if (cpu_req && streak_q != MAX_STREAK) begin
          streak_d = streak_q + 4'd1;
        end
      end

      ACCESS: begin
        cnt_d = cnt_q + 4'd1;
        if (last_beat) begin
          state_d = RESP;
          cnt_d   = 4'd0;
          if (!we_q) begin
            if (grant_ld_q) begin
              ld_rdata_d = mem_rdata;
            end else begin
              cpu_rdata_d = mem_rdata;
            end
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      streak_q    <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      grant_ld_q  <= 1'b0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      grant_ld_q  <= grant_ld_d;
      cpu_rdata_q <= cpu_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  // Memory side is only driven during ACCESS; the write strobe fires on
  // the final wait cycle so the address has been stable for the whole access.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == ACCESS) begin
      mem_en    = 1'b1;
      mem_we    = we_q & last_beat;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
    end
  end

  assign cpu_ack   = (state_q == RESP) & ~grant_ld_q;
  assign ld_ack    = (state_q == RESP) &  grant_ld_q;
  // Gated by rst so the decoder sees no stall while the arbiter is held in reset.
  assign cpu_stall = rst & cpu_req & ~cpu_ack;
  assign cpu_rdata = cpu_rdata_q;
  assign ld_rdata  = ld_rdata_q;
  assign grant_ld  = grant_ld_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Three instances share one set of
// inputs: u_dut (WAIT_CYCLES=2, MAX_CPU_STREAK=4), u_str (streak limit 2)
// and u_zero (WAIT_CYCLES=0). Cycle numbers in the scenarios count from
// the IDLE cycle in which the request is first presented.

module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, ld_req, ld_we;
  logic [31:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata, mem_rdata;

  logic [31:0] cpu_rdata, ld_rdata, mem_addr, mem_wdata;
  logic        cpu_ack, cpu_stall, ld_ack, mem_en, mem_we, grant_ld;

  logic [31:0] s_cpu_rdata, s_ld_rdata, s_mem_addr, s_mem_wdata;
  logic        s_cpu_ack, s_cpu_stall, s_ld_ack, s_mem_en, s_mem_we, s_grant_ld;

  logic [31:0] z_cpu_rdata, z_ld_rdata, z_mem_addr, z_mem_wdata;
  logic        z_cpu_ack, z_cpu_stall, z_ld_ack, z_mem_en, z_mem_we, z_grant_ld;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.WAIT_CYCLES(2), .MAX_CPU_STREAK(4)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_ack(ld_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant_ld(grant_ld)
  );

  mem_port_arbiter #(.WAIT_CYCLES(2), .MAX_CPU_STREAK(2)) u_str (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(s_cpu_rdata), .cpu_ack(s_cpu_ack), .cpu_stall(s_cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(s_ld_rdata), .ld_ack(s_ld_ack),
    .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_rdata(mem_rdata), .grant_ld(s_grant_ld)
  );

  mem_port_arbiter #(.WAIT_CYCLES(0), .MAX_CPU_STREAK(4)) u_zero (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(z_cpu_rdata), .cpu_ack(z_cpu_ack), .cpu_stall(z_cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(z_ld_rdata), .ld_ack(z_ld_ack),
    .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
    .mem_rdata(mem_rdata), .grant_ld(z_grant_ld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic creq, input logic cwe,
                               input logic [31:0] caddr, input logic [31:0] cwdata,
                               input logic lreq, input logic lwe,
                               input logic [31:0] laddr, input logic [31:0] lwdata);
    cpu_req   = creq;
    cpu_we    = cwe;
    cpu_addr  = caddr;
    cpu_wdata = cwdata;
    ld_req    = lreq;
    ld_we     = lwe;
    ld_addr   = laddr;
    ld_wdata  = lwdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkFlag(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Leaves the bench just after a rising edge with reset released.
  task automatic pulseReset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    mem_rdata = 32'h0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkFlag("reset_cpu_ack", cpu_ack, 1'b0);
    checkFlag("reset_ld_ack", ld_ack, 1'b0);
    checkFlag("reset_mem_en", mem_en, 1'b0);
    checkFlag("reset_grant_ld", grant_ld, 1'b0);
    checkOutput("reset_mem_addr", mem_addr, 32'h0);
    checkOutput("reset_cpu_rdata", cpu_rdata, 32'h0);

    // Reset in the middle of a CPU write: outputs clear immediately and
    // the pending write strobe never appears.
    #1 rst = 1'b1;
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h30, 32'hAAAA5555, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkFlag("rstw_c0_stall", cpu_stall, 1'b1);
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkFlag("rstw_c2_en", mem_en, 1'b1);
    checkFlag("rstw_c2_we", mem_we, 1'b0);
    checkOutput("rstw_c2_addr", mem_addr, 32'h30);
    #1 rst = 1'b0;
    #1;
    checkFlag("rstw_async_en", mem_en, 1'b0);
    checkOutput("rstw_async_addr", mem_addr, 32'h0);
    checkOutput("rstw_async_wdata", mem_wdata, 32'h0);
    checkFlag("rstw_async_stall", cpu_stall, 1'b0);
    nextCycle();
    @(negedge clk);
    checkFlag("rstw_held_we", mem_we, 1'b0);
    checkFlag("rstw_held_en", mem_en, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      checkFlag($sformatf("rstw_fresh_c%0d_ack", c), cpu_ack, c == 4);
      checkFlag($sformatf("rstw_fresh_c%0d_we", c), mem_we, c == 3);
      if (c == 3) checkOutput("rstw_fresh_wdata", mem_wdata, 32'hAAAA5555);
      if (c == 4) checkOutput("rstw_fresh_rdata", cpu_rdata, 32'h0);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // CPU read from 0x10.
    pulseReset();
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    mem_rdata = 32'hDEADBEEF;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      checkFlag($sformatf("rd_c%0d_en", c), mem_en, (c >= 1) && (c <= 3));
      checkFlag($sformatf("rd_c%0d_stall", c), cpu_stall, c <= 3);
      checkFlag($sformatf("rd_c%0d_ack", c), cpu_ack, c == 4);
      checkFlag($sformatf("rd_c%0d_ldack", c), ld_ack, 1'b0);
      if (c == 2) checkOutput("rd_addr", mem_addr, 32'h10);
      if (c == 4) checkOutput("rd_rdata", cpu_rdata, 32'hDEADBEEF);
      nextCycle();
    end

    // Loader write to 0x40; read data registers must not move.
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h12345678);
    mem_rdata = 32'hCAFEF00D;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      checkFlag($sformatf("ldw_c%0d_we", c), mem_we, c == 3);
      checkFlag($sformatf("ldw_c%0d_en", c), mem_en, (c >= 1) && (c <= 3));
      checkFlag($sformatf("ldw_c%0d_ldack", c), ld_ack, c == 4);
      if (c == 3) begin
        checkOutput("ldw_addr", mem_addr, 32'h40);
        checkOutput("ldw_wdata", mem_wdata, 32'h12345678);
      end
      if (c == 4) begin
        checkFlag("ldw_cpu_ack", cpu_ack, 1'b0);
        checkFlag("ldw_grant", grant_ld, 1'b1);
        checkOutput("ldw_ld_rdata", ld_rdata, 32'h0);
        checkOutput("ldw_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
      end
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkFlag("ldw_idle_grant_hold", grant_ld, 1'b1);
    checkFlag("ldw_idle_en", mem_en, 1'b0);

    // Contention: CPU read 0x20 served first, loader read 0x80 afterwards.
    pulseReset();
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0);
    mem_rdata = 32'h11112222;
    for (int c = 0; c <= 9; c++) begin
      if (c == 5) begin
        cpu_req   = 1'b0;
        mem_rdata = 32'h33334444;
      end
      @(negedge clk);
      checkFlag($sformatf("con_c%0d_cpuack", c), cpu_ack, c == 4);
      checkFlag($sformatf("con_c%0d_ldack", c), ld_ack, c == 9);
      if (c == 0) checkFlag("con_c0_stall", cpu_stall, 1'b1);
      if (c == 2) begin
        checkFlag("con_c2_grant", grant_ld, 1'b0);
        checkOutput("con_c2_addr", mem_addr, 32'h20);
      end
      if (c == 7) begin
        checkFlag("con_c7_grant", grant_ld, 1'b1);
        checkOutput("con_c7_addr", mem_addr, 32'h80);
      end
      if (c == 4) checkOutput("con_cpu_rdata", cpu_rdata, 32'h11112222);
      if (c == 9) begin
        checkOutput("con_ld_rdata", ld_rdata, 32'h33334444);
        checkOutput("con_cpu_rdata_hold", cpu_rdata, 32'h11112222);
      end
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Starvation: both held; u_str (limit 2) goes CPU, CPU, loader, CPU,
    // while u_dut (limit 4) keeps serving the CPU.
    pulseReset();
    applyStimulus(1'b1, 1'b0, 32'h50, 32'h0, 1'b1, 1'b0, 32'h60, 32'h0);
    mem_rdata = 32'h0BADF00D;
    for (int c = 0; c <= 16; c++) begin
      if (c == 15) ld_req = 1'b0;
      @(negedge clk);
      if (c == 1 || c == 6 || c == 11 || c == 16)
        checkFlag($sformatf("str_c%0d_grant", c), s_grant_ld, c == 11);
      checkFlag($sformatf("str_c%0d_ldack", c), s_ld_ack, c == 14);
      checkFlag($sformatf("str_c%0d_cpuack", c), s_cpu_ack, (c == 4) || (c == 9));
      if (c == 11) begin
        checkFlag("str_c11_dut_grant", grant_ld, 1'b0);
        checkOutput("str_c11_addr", s_mem_addr, 32'h60);
      end
      if (c == 12) checkFlag("str_c12_stall", s_cpu_stall, 1'b1);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // WAIT_CYCLES=0: one ACCESS cycle, ack two cycles after the request,
    // a held request restarts after exactly one IDLE cycle.
    pulseReset();
    applyStimulus(1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    mem_rdata = 32'h5A5A5A5A;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      checkFlag($sformatf("zero_c%0d_en", c), z_mem_en, (c == 1) || (c == 4));
      checkFlag($sformatf("zero_c%0d_ack", c), z_cpu_ack, (c == 2) || (c == 5));
      if (c == 1) checkOutput("zero_addr", z_mem_addr, 32'h44);
      if (c == 2) checkOutput("zero_rdata", z_cpu_rdata, 32'h5A5A5A5A);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
